// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Load/store front end for a 2**RAM_AW x 16 data RAM. It accepts 16-bit and
//   32-bit byte-addressed CPU requests and runs one or two 16-bit RAM cycles
//   for each one. Data is little-endian, so the low halfword sits at the even
//   index. Misaligned requests are answered with resp_err and never reach the
//   RAM.
//
// Ports
//   clk, rst          : clock; synchronous active-high reset
//   req_valid/ready   : request handshake (req_ready is high only in IDLE)
//   req_we, req_size  : 1=store / 0=load; 0=halfword / 1=word
//   req_addr          : byte address, RAM_AW+1 bits
//   req_wdata         : store data
//   req_signed        : sign-extend halfword loads (only with RAM_ACC_SIGN_EXT_EN)
//   resp_valid/ready  : response handshake
//   resp_rdata        : load data (0 for stores and errors)
//   resp_err          : misaligned request
//   ram_write_n       : RAM write enable, active low
//   ram_addr          : RAM halfword index
//   ram_data_in       : RAM write data
//   ram_data_out      : RAM read data, combinational from ram_addr
//
// Build option
//   RAM_ACC_SIGN_EXT_EN : adds req_signed and sign extension of halfword loads.
module ram_access_ctrl #(
  parameter int unsigned RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_size,
  input  logic [RAM_AW:0]   req_addr,
  input  logic [31:0]       req_wdata,
`ifdef RAM_ACC_SIGN_EXT_EN
  input  logic              req_signed,
`endif
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_write_n,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_data_in,
  input  logic [15:0]       ram_data_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic              we_q,       we_d;
  logic              size_q,     size_d;
  logic              sext_q,     sext_d;
  logic [31:0]       wdata_q,    wdata_d;
  logic [31:0]       rdata_q,    rdata_d;
  logic              err_q,      err_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;

  logic misaligned;
  logic req_sext;

`ifdef RAM_ACC_SIGN_EXT_EN
  assign req_sext = req_signed;
`else
  assign req_sext = 1'b0;
`endif

  assign misaligned = req_size ? (req_addr[1:0] != 2'b00) : req_addr[0];

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    sext_d     = sext_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    ram_addr_d = ram_addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sext_d  = req_sext;
          wdata_d = req_wdata;
          rdata_d = '0;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d = 1'b0;
            // The index is registered here so it is already valid during LO.
            ram_addr_d = req_addr[RAM_AW:1];
            state_d    = LO;
          end
        end
      end
      LO: begin
        if (!we_q) begin
          rdata_d[15:0] = ram_data_out;
          if (!size_q && sext_q) rdata_d[31:16] = {16{ram_data_out[15]}};
        end
        if (size_q) begin
          // Word alignment keeps this index even, so the increment cannot wrap.
          ram_addr_d = ram_addr_q + 1'b1;
          state_d    = HI;
        end else begin
          state_d = RESP;
        end
      end
      HI: begin
        if (!we_q) rdata_d[31:16] = ram_data_out;
        state_d = RESP;
      end
      default: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 1'b0;
      sext_q     <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      ram_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ram_addr   = ram_addr_q;

  // rst gates the write strobe so an aborted cycle does not commit at the
  // same edge that resets the controller.
  assign ram_write_n = rst || !we_q || !((state_q == LO) || (state_q == HI));

  always_comb begin
    ram_data_in = '0;
    if (state_q == LO)      ram_data_in = wdata_q[15:0];
    else if (state_q == HI) ram_data_in = wdata_q[31:16];
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
module tb_ram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_size, req_signed;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_write_n;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data_in, ram_data_out;

  logic [15:0] mem [1024];
  logic        mem_clr;
  int          cyc = 0;

  int checks = 0;
  int errors = 0;

  logic [31:0] got_rdata;
  logic        got_err;
  int          got_lat, got_wrn, acc_cycle;

  always #5 clk = ~clk;

  ram_access_ctrl #(.RAM_AW(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef RAM_ACC_SIGN_EXT_EN
    .req_signed(req_signed),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_write_n(ram_write_n), .ram_addr(ram_addr),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
  );

  // 1024x16 RAM: combinational read, write on rising edge.
  assign ram_data_out = mem[ram_addr];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    end else if (!ram_write_n) begin
      mem[ram_addr] <= ram_data_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assumes inputs are set; waits (bounded) for the accepting edge.
  task automatic wait_accept(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        tick();
        acc_cycle = cyc;
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s accept: got timeout expected req_ready", name);
    end
  endtask

  task automatic wait_resp(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s resp: got timeout expected resp_valid", name);
    end
  endtask

  // Full transaction with resp_ready=1; records data, latency and write cycles.
  task automatic do_req(input string name, input logic we, input logic size,
                        input logic [10:0] addr, input logic [31:0] wdata,
                        input logic sgn);
    logic ok;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_addr   = addr;
    req_wdata  = wdata;
    req_signed = sgn;
    resp_ready = 1'b1;
    wait_accept(name);
    req_valid = 1'b0;
    req_wdata = 32'h0;
    got_lat = 0;
    got_wrn = 0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      got_lat++;
      if (!ram_write_n) got_wrn++;
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s resp: got timeout expected resp_valid", name);
    end
    got_rdata = resp_rdata;
    got_err   = resp_err;
    tick();
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic        size;
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wrn;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{"st_w_010",  1'b1, 1'b1, 11'h010, 32'hDEADBEEF, 32'h0,        1'b0, 3, 2};
    vecs[1] = '{"ld_w_010",  1'b0, 1'b1, 11'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 0};
    vecs[2] = '{"st_h_7fe",  1'b1, 1'b0, 11'h7FE, 32'h55558001, 32'h0,        1'b0, 2, 1};
    vecs[3] = '{"ld_h_7fe",  1'b0, 1'b0, 11'h7FE, 32'h0,        32'h00008001, 1'b0, 2, 0};
    vecs[4] = '{"ld_w_006",  1'b0, 1'b1, 11'h006, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[5] = '{"st_h_003",  1'b1, 1'b0, 11'h003, 32'h0000FFFF, 32'h0,        1'b1, 1, 0};
    vecs[6] = '{"ld_h_002",  1'b0, 1'b0, 11'h002, 32'h0,        32'h0,        1'b0, 2, 0};
    vecs[7] = '{"ld_h_012",  1'b0, 1'b0, 11'h012, 32'h0,        32'h0000DEAD, 1'b0, 2, 0};
    vecs[8] = '{"ld_h_010",  1'b0, 1'b0, 11'h010, 32'h0,        32'h0000BEEF, 1'b0, 2, 0};

    rst = 1'b1; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0; req_addr = '0;
    req_wdata = '0; req_signed = 1'b0; resp_ready = 1'b1;
    tick(); tick();
    mem_clr = 1'b0;
    rst = 1'b0;

    chk("rst_req_ready",  32'(req_ready),   32'h1);
    chk("rst_resp_valid", 32'(resp_valid),  32'h0);
    chk("rst_resp_rdata", resp_rdata,       32'h0);
    chk("rst_resp_err",   32'(resp_err),    32'h0);
    chk("rst_write_n",    32'(ram_write_n), 32'h1);
    chk("rst_ram_addr",   32'(ram_addr),    32'h0);
    chk("rst_data_in",    32'(ram_data_in), 32'h0);

    for (int v = 0; v < 9; v++) begin
      do_req(vecs[v].name, vecs[v].we, vecs[v].size, vecs[v].addr, vecs[v].wdata, 1'b0);
      chk({vecs[v].name, "_rdata"}, got_rdata,        vecs[v].exp_rdata);
      chk({vecs[v].name, "_err"},   32'(got_err),     32'(vecs[v].exp_err));
      chk({vecs[v].name, "_lat"},   32'(got_lat),     32'(vecs[v].exp_lat));
      chk({vecs[v].name, "_wrn"},   32'(got_wrn),     32'(vecs[v].exp_wrn));
    end
    chk("mem8",    32'(mem[8]),    32'h0000BEEF);
    chk("mem9",    32'(mem[9]),    32'h0000DEAD);
    chk("mem1023", 32'(mem[1023]), 32'h00008001);
    chk("mem1",    32'(mem[1]),    32'h0);

`ifdef RAM_ACC_SIGN_EXT_EN
    do_req("ld_h_7fe_s", 1'b0, 1'b0, 11'h7FE, 32'h0, 1'b1);
    chk("ld_h_7fe_s_rdata", got_rdata, 32'hFFFF8001);
    do_req("ld_w_010_s", 1'b0, 1'b1, 11'h010, 32'h0, 1'b1);
    chk("ld_w_010_s_rdata", got_rdata, 32'hDEADBEEF);
`endif

    // Response backpressure with a competing request held on the inputs.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 1'b1; req_addr = 11'h010;
    wait_accept("bp_load");
    req_size = 1'b0; req_addr = 11'h012;
    wait_resp("bp_load");
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 32'h1);
      chk("bp_resp_rdata", resp_rdata,      32'hDEADBEEF);
      chk("bp_req_ready",  32'(req_ready),  32'h0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_idle_req_ready",  32'(req_ready),  32'h1);
    chk("bp_idle_resp_valid", 32'(resp_valid), 32'h0);
    tick();
    req_valid = 1'b0;
    chk("bp_next_accepted", 32'(req_ready), 32'h0);
    wait_resp("bp_next");
    chk("bp_next_rdata", resp_rdata, 32'h0000DEAD);
    tick();

    // Reset while the high half of a word store is on the RAM pins.
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b1; req_addr = 11'h020;
    req_wdata = 32'h12345678;
    wait_accept("rst_hi");
    req_valid = 1'b0;
    chk("rst_hi_lo_wrn",  32'(ram_write_n), 32'h0);
    tick();
    chk("rst_hi_addr",    32'(ram_addr),    32'd17);
    chk("rst_hi_data_in", 32'(ram_data_in), 32'h1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_hi_req_ready",  32'(req_ready),   32'h1);
    chk("rst_hi_resp_valid", 32'(resp_valid),  32'h0);
    chk("rst_hi_rdata",      resp_rdata,       32'h0);
    chk("rst_hi_err",        32'(resp_err),    32'h0);
    chk("rst_hi_write_n",    32'(ram_write_n), 32'h1);
    chk("rst_hi_ram_addr",   32'(ram_addr),    32'h0);
    chk("rst_hi_data_in0",   32'(ram_data_in), 32'h0);
    chk("rst_hi_mem16",      32'(mem[16]),     32'h5678);
    chk("rst_hi_mem17",      32'(mem[17]),     32'h0);

    // Back-to-back halfword store/load pairs at indices 0..3.
    begin
      int prev;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
        do_req("b2b_st", 1'b1, 1'b0, 11'(2 * i), {16'hFFFF, 16'hA5A0 + 16'(i)}, 1'b0);
        if (i > 0) chk("b2b_spacing_st", 32'(acc_cycle - prev), 32'd3);
        prev = acc_cycle;
        do_req("b2b_ld", 1'b0, 1'b0, 11'(2 * i), 32'h0, 1'b0);
        chk("b2b_spacing_ld", 32'(acc_cycle - prev), 32'd3);
        prev = acc_cycle;
        chk("b2b_rdata", got_rdata, {16'h0000, 16'hA5A0 + 16'(i)});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
